// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter and sequencer for the processor data memory.
//            Round-robin on simultaneous requests when DMEM_ARB_RR_EN is
//            defined, otherwise fixed priority with port 0 winning.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [1:0]        req_we_i,
    input  logic [2*AW-1:0]   req_addr_i,
    input  logic [2*DW-1:0]   req_wdata_i,
    output logic [1:0]        rsp_valid_o,
    output logic [DW-1:0]     rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [AW-1:0]     mem_address_o,
    output logic [DW-1:0]     mem_write_data_o,
    output logic              mem_write_enable_o,
    output logic              mem_read_enable_o,
    input  logic [DW-1:0]     mem_read_data_i
);

    localparam logic [1:0]    c_st_idle    = 2'd0;
    localparam logic [1:0]    c_st_issue   = 2'd1;
    localparam logic [1:0]    c_st_capture = 2'd2;
    localparam logic [AW-1:0] c_depth      = AW'(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_port;
    logic          r_we;
    logic          r_oor;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_mem_re;
    logic          r_mem_we;
    logic [1:0]    r_rsp_valid;
    logic          r_rsp_err;

    logic          w_grant;
    logic          w_handshake;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_sel_in_range;
    logic          w_mem_re_nxt;
    logic          w_mem_we_nxt;
    logic [1:0]    w_rsp_valid_nxt;
    logic          w_rsp_err_nxt;

`ifdef DMEM_ARB_RR_EN
    // Pointer holds the port granted last; reset to port 1 so port 0 wins first.
    logic r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_handshake) begin
            r_last <= w_grant;
        end
    end

    always_comb begin
        w_grant = ~req_valid_i[0];
        if (req_valid_i == 2'b11) begin
            w_grant = ~r_last;
        end
    end
`else
    always_comb begin
        w_grant = ~req_valid_i[0];
    end
`endif

    assign w_sel_we       = w_grant ? req_we_i[1] : req_we_i[0];
    assign w_sel_addr     = w_grant ? req_addr_i[2*AW-1:AW] : req_addr_i[AW-1:0];
    assign w_sel_wdata    = w_grant ? req_wdata_i[2*DW-1:DW] : req_wdata_i[DW-1:0];
    assign w_sel_in_range = (w_sel_addr < c_depth);
    assign w_handshake    = |req_ready_o;

    // State register plus all registered outputs and the latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            if (w_handshake) begin
                r_port  <= w_grant;
                r_we    <= w_sel_we;
                r_oor   <= ~w_sel_in_range;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = c_st_idle;
        case (r_state)
            c_st_idle:    w_state_nxt = w_handshake ? c_st_issue : c_st_idle;
            c_st_issue:   w_state_nxt = c_st_capture;
            c_st_capture: w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        req_ready_o     = 2'b00;
        w_mem_re_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_rsp_valid_nxt = 2'b00;
        w_rsp_err_nxt   = 1'b0;
        if ((r_state == c_st_idle) && !reset) begin
            req_ready_o = (w_grant ? 2'b10 : 2'b01) & req_valid_i;
        end
        if (w_handshake) begin
            w_mem_re_nxt = ~w_sel_we & w_sel_in_range;
            w_mem_we_nxt =  w_sel_we & w_sel_in_range;
        end
        if (r_state == c_st_issue) begin
            w_rsp_valid_nxt = r_port ? 2'b10 : 2'b01;
            w_rsp_err_nxt   = r_oor;
        end
    end

    // Memory data is valid the cycle after the read pulse, i.e. during CAPTURE.
    assign rsp_rdata_o        = ((r_rsp_valid != 2'b00) && !r_we && !r_oor) ? mem_read_data_i : '0;
    assign rsp_valid_o        = r_rsp_valid;
    assign rsp_err_o          = r_rsp_err;
    assign mem_address_o      = r_addr;
    assign mem_write_data_o   = r_wdata;
    assign mem_read_enable_o  = r_mem_re;
    assign mem_write_enable_o = r_mem_we;

endmodule
`default_nettype wire
